// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS execute stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fixed up in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      iterCnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operandB;
  logic [WIDTH-1:0]   origA;
  logic               isDiv;
  logic               negLow;
  logic               negHigh;
  logic               divZero;

  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  assign busy = (state != IDLE);

  always_comb begin
    aNeg = ~op[0] & src_a[WIDTH-1];
    bNeg = ~op[0] & src_b[WIDTH-1];
    absA = aNeg ? -src_a : src_a;
    absB = bNeg ? -src_b : src_b;

    // acc = {partial product, remaining multiplier bits}; shift right one per cycle
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operandB} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};

    // acc = {partial remainder, dividend/quotient}; remainder < divisor keeps the
    // subtraction within WIDTH bits whenever it fits
    divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divFits  = (divShift >= {1'b0, operandB});
    divRem   = divFits ? (divShift[WIDTH-1:0] - operandB) : divShift[WIDTH-1:0];
    divNext  = {divRem, acc[WIDTH-2:0], divFits};

    product = negLow ? -acc : acc;
    quotFix = negLow ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix  = negHigh ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      iterCnt  <= '0;
      acc      <= '0;
      operandB <= '0;
      origA    <= '0;
      isDiv    <= 1'b0;
      negLow   <= 1'b0;
      negHigh  <= 1'b0;
      divZero  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            state    <= CALC;
            iterCnt  <= '0;
            acc      <= {{WIDTH{1'b0}}, absA};
            operandB <= absB;
            origA    <= src_a;
            isDiv    <= op[1];
            negLow   <= aNeg ^ bNeg;
            negHigh  <= aNeg;
            divZero  <= op[1] && (src_b == '0);
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc     <= isDiv ? divNext : mulNext;
            iterCnt <= iterCnt + 1'b1;
            if (iterCnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (divZero) begin
              hi <= origA;
              lo <= '1;
            end else if (isDiv) begin
              hi <= remFix;
              lo <= quotFix;
            end else begin
              hi <= product[2*WIDTH-1:WIDTH];
              lo <= product[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: 32-bit instance for the main cases, 8-bit instance for narrow corners.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        flush = 1'b0;
  logic        hiWe = 1'b0;
  logic        loWe = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  srcA8 = '0;
  logic [7:0]  srcB8 = '0;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(srcA), .src_b(srcB),
    .flush(flush), .hi_we(hiWe), .lo_we(loWe), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(srcA8), .src_b(srcB8),
    .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Call at a falling edge: start is presented for cycle 0.
  task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
  endtask

  // Observes cycles 1..maxCyc at falling edges; optionally re-asserts start or flush in one cycle.
  task automatic watch(input int maxCyc, input int extraStartCyc, input int flushCyc,
                       output int doneAt, output int lastBusy, output int doneCnt);
    doneAt = -1;
    lastBusy = -1;
    doneCnt = 0;
    for (int c = 1; c <= maxCyc; c++) begin
      @(negedge clk);
      if (busy) lastBusy = c;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = c;
      end
      start = (c == extraStartCyc);
      flush = (c == flushCyc);
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_held busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_released busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
    end
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mult;
    int dAt, lBusy, dCnt;
    startOp(2'b00, 32'hFFFFFFFD, 32'h00000007);
    watch(38, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (dAt != 34 || lBusy != 33 || dCnt != 1) begin
      miscompares++;
      $display("FAIL mult_timing doneAt=%0d lastBusy=%0d doneCnt=%0d required 34/33/1", dAt, lBusy, dCnt);
    end
    vectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL mult_result hi=%h lo=%h required FFFFFFFF/FFFFFFEB", hi, lo);
    end
    $display("MULT FFFFFFFD*7: hi=%h lo=%h done@%0d", hi, lo, dAt);
  endtask

  task automatic test_back_to_back;
    int dAt, lBusy, dCnt;
    startOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    watch(34, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (dAt != 34 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      miscompares++;
      $display("FAIL multu_result doneAt=%0d hi=%h lo=%h required 34/FFFFFFFE/00000001", dAt, hi, lo);
    end
    $display("MULTU FFFFFFFF*FFFFFFFF: hi=%h lo=%h done@%0d", hi, lo, dAt);
    // Issue DIVU 100/7 in the done cycle itself.
    startOp(2'b11, 32'd100, 32'd7);
    watch(36, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (dAt != 34 || dCnt != 1 || hi !== 32'd2 || lo !== 32'd14) begin
      miscompares++;
      $display("FAIL back_to_back doneAt=%0d doneCnt=%0d hi=%h lo=%h required 34/1/2/14", dAt, dCnt, hi, lo);
    end
    $display("DIVU 100/7 back-to-back: hi=%h lo=%h done@%0d", hi, lo, dAt);
  endtask

  task automatic test_div;
    int dAt, lBusy, dCnt;
    startOp(2'b10, 32'hFFFFFFF9, 32'h00000002);
    watch(36, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (dAt != 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      miscompares++;
      $display("FAIL div_neg doneAt=%0d hi=%h lo=%h required 34/FFFFFFFF/FFFFFFFD", dAt, hi, lo);
    end
    $display("DIV FFFFFFF9/2: hi=%h lo=%h", hi, lo);
    startOp(2'b10, 32'h80000000, 32'hFFFFFFFF);
    watch(36, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (dAt != 34 || hi !== 32'h0 || lo !== 32'h80000000) begin
      miscompares++;
      $display("FAIL div_overflow doneAt=%0d hi=%h lo=%h required 34/0/80000000", dAt, hi, lo);
    end
    $display("DIV 80000000/FFFFFFFF: hi=%h lo=%h", hi, lo);
    startOp(2'b10, 32'd17, 32'hFFFFFFFB);
    watch(36, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (hi !== 32'd2 || lo !== 32'hFFFFFFFD) begin
      miscompares++;
      $display("FAIL div_pos_by_neg hi=%h lo=%h required 00000002/FFFFFFFD", hi, lo);
    end
    $display("DIV 17/-5: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_div_zero;
    int dAt, lBusy, dCnt;
    startOp(2'b11, 32'd5, 32'd0);
    watch(45, 5, -1, dAt, lBusy, dCnt);
    vectors++;
    if (dAt != 34 || dCnt != 1 || lBusy != 33) begin
      miscompares++;
      $display("FAIL divu_zero_timing doneAt=%0d doneCnt=%0d lastBusy=%0d required 34/1/33", dAt, dCnt, lBusy);
    end
    vectors++;
    if (hi !== 32'h5 || lo !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL divu_zero_result hi=%h lo=%h required 00000005/FFFFFFFF", hi, lo);
    end
    $display("DIVU 5/0 with stray start@5: hi=%h lo=%h dones=%0d", hi, lo, dCnt);
    startOp(2'b10, 32'hFFFFFFF0, 32'd0);
    watch(36, -1, -1, dAt, lBusy, dCnt);
    vectors++;
    if (hi !== 32'hFFFFFFF0 || lo !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL div_zero_signed hi=%h lo=%h required FFFFFFF0/FFFFFFFF", hi, lo);
    end
    $display("DIV FFFFFFF0/0: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_flush;
    int dAt, lBusy, dCnt;
    hiWe = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    hiWe = 1'b0;
    loWe = 1'b1;
    wdata = 32'h5678;
    @(negedge clk);
    loWe = 1'b0;
    @(negedge clk);
    vectors++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      miscompares++;
      $display("FAIL mthi_mtlo hi=%h lo=%h required 00001234/00005678", hi, lo);
    end
    $display("MTHI/MTLO: hi=%h lo=%h", hi, lo);
    // start together with flush in IDLE must not issue
    startOp(2'b00, 32'd3, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_with_flush busy=%b required 0", busy);
    end
    $display("start+flush in IDLE: busy=%b", busy);
    startOp(2'b11, 32'd1000, 32'd3);
    watch(40, -1, 10, dAt, lBusy, dCnt);
    vectors++;
    if (lBusy != 10 || dCnt != 0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      miscompares++;
      $display("FAIL flush_calc lastBusy=%0d doneCnt=%0d hi=%h lo=%h required 10/0/00001234/00005678",
               lBusy, dCnt, hi, lo);
    end
    $display("DIVU flushed@10: lastBusy=%0d dones=%0d hi=%h lo=%h", lBusy, dCnt, hi, lo);
  endtask

  task automatic test_reset_mid;
    int dAt, lBusy, dCnt;
    startOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    watch(8, -1, -1, dAt, lBusy, dCnt);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
    end
    $display("rst mid-CALC: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_width8;
    int dAt;
    logic [1:0] ops [2] = '{2'b00, 2'b10};
    logic [7:0] as [2] = '{8'h80, 8'h80};
    logic [7:0] bs [2] = '{8'h80, 8'hFF};
    logic [7:0] expHi [2] = '{8'h40, 8'h00};
    logic [7:0] expLo [2] = '{8'h00, 8'h80};
    for (int t = 0; t < 2; t++) begin
      start8 = 1'b1;
      op8 = ops[t];
      srcA8 = as[t];
      srcB8 = bs[t];
      dAt = -1;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        start8 = 1'b0;
        if (done8 && dAt < 0) dAt = c;
      end
      vectors++;
      if (dAt != 10 || hi8 !== expHi[t] || lo8 !== expLo[t]) begin
        miscompares++;
        $display("FAIL w8_case%0d doneAt=%0d hi=%h lo=%h required 10/%h/%h", t, dAt, hi8, lo8, expHi[t], expLo[t]);
      end
      $display("W8 op=%b %h,%h: hi=%h lo=%h done@%0d", ops[t], as[t], bs[t], hi8, lo8, dAt);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_back_to_back;
    test_div;
    test_div_zero;
    test_flush;
    test_reset_mid;
    test_width8;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
